// File: rtl/terminal_arbiter_pkg.sv
// Shared types and constants for the two-station terminal arbiter.
// The slot state encoding doubles as the one-hot grant vector.
package terminal_arbiter_pkg;

  localparam int CODE_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } slot_state_t;

  localparam logic DST_MTX = 1'b0;
  localparam logic DST_LED = 1'b1;

  function automatic slot_state_t own_state(input logic stn);
    return stn ? ST_OWN1 : ST_OWN0;
  endfunction

  function automatic logic [CODE_W-1:0] pick_code(input logic stn,
                                                  input logic [CODE_W-1:0] c0,
                                                  input logic [CODE_W-1:0] c1);
    return stn ? c1 : c0;
  endfunction

endpackage

// File: rtl/terminal_arbiter_slot.sv
// Single-terminal ownership FSM: round-robin pointer, bounded hold counter
// and the function-code register forwarded to the terminal decoder.
module terminal_slot_arbiter
  import terminal_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [CODE_W-1:0] code0,
  input  logic [CODE_W-1:0] code1,
  output logic [1:0]        gnt,
  output logic              valid,
  output logic [CODE_W-1:0] code,
  output logic              valid_nxt,
  output logic              evt,
  output logic              evt_stn
);

  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  slot_state_t       state_r, state_nxt_s;
  logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
  logic              ptr_r, ptr_nxt_s;
  logic [CODE_W-1:0] code_r, code_nxt_s;
  logic              own_stn_s, own_req_s, oth_req_s;

  assign own_stn_s = (state_r == ST_OWN1);
  assign own_req_s = own_stn_s ? req1 : req0;
  assign oth_req_s = own_stn_s ? req0 : req1;

  // Next-state, counter, pointer and code selection.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    ptr_nxt_s   = ptr_r;
    code_nxt_s  = code_r;
    case (state_r)
      ST_IDLE: begin
        if (req0 && req1) begin
          state_nxt_s = own_state(ptr_r);
          cnt_nxt_s   = {CNT_W{1'b0}};
          ptr_nxt_s   = ~ptr_r;
          code_nxt_s  = pick_code(ptr_r, code0, code1);
        end else if (req0 || req1) begin
          state_nxt_s = own_state(req1);
          cnt_nxt_s   = {CNT_W{1'b0}};
          ptr_nxt_s   = ~req1;
          code_nxt_s  = pick_code(req1, code0, code1);
        end else begin
          cnt_nxt_s   = {CNT_W{1'b0}};
          code_nxt_s  = {CODE_W{1'b0}};
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (!own_req_s) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
          ptr_nxt_s   = ~own_stn_s;
          code_nxt_s  = {CODE_W{1'b0}};
        end else if (oth_req_s && (cnt_r == CNT_MAX)) begin
          // Hold time exhausted under contention: hand over with no idle gap.
          state_nxt_s = own_state(~own_stn_s);
          cnt_nxt_s   = {CNT_W{1'b0}};
          ptr_nxt_s   = own_stn_s;
          code_nxt_s  = pick_code(~own_stn_s, code0, code1);
        end else begin
          cnt_nxt_s   = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          code_nxt_s  = pick_code(own_stn_s, code0, code1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
        ptr_nxt_s   = 1'b0;
        code_nxt_s  = {CODE_W{1'b0}};
      end
    endcase
  end

  // Slot state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      ptr_r   <= 1'b0;
      code_r  <= {CODE_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ptr_r   <= ptr_nxt_s;
      code_r  <= code_nxt_s;
    end
  end

  assign gnt       = state_r;
  assign valid     = (state_r != ST_IDLE);
  assign code      = code_r;
  assign valid_nxt = (state_nxt_s != ST_IDLE);
  assign evt       = (state_nxt_s != ST_IDLE) && (state_nxt_s != state_r);
  assign evt_stn   = (state_nxt_s == ST_OWN1);

endmodule

// File: rtl/terminal_arbiter.sv
// Shares the LED matrix and LED bar between two stations; steers requests to
// the per-terminal slot arbiters and tracks which station the 7-seg shows.
module terminal_arbiter
  import terminal_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              REQ0,
  input  logic              DST0,
  input  logic [CODE_W-1:0] CODE0,
  input  logic              REQ1,
  input  logic              DST1,
  input  logic [CODE_W-1:0] CODE1,
  output logic [1:0]        MTX_GNT,
  output logic              MTX_VALID,
  output logic [CODE_W-1:0] MTX_CODE,
  output logic [1:0]        LED_GNT,
  output logic              LED_VALID,
  output logic [CODE_W-1:0] LED_CODE,
  output logic              SEG_SEL,
  output logic              SEG_VALID
);

  logic mtx_req0_s, mtx_req1_s, led_req0_s, led_req1_s;
  logic mtx_valid_nxt_s, mtx_evt_s, mtx_evt_stn_s;
  logic led_valid_nxt_s, led_evt_s, led_evt_stn_s;
  logic seg_sel_r, seg_valid_r;

  // A station targets exactly one terminal, so it can never own both.
  assign mtx_req0_s = REQ0 & (DST0 == DST_MTX);
  assign mtx_req1_s = REQ1 & (DST1 == DST_MTX);
  assign led_req0_s = REQ0 & (DST0 == DST_LED);
  assign led_req1_s = REQ1 & (DST1 == DST_LED);

  terminal_slot_arbiter #(.MAX_HOLD(MAX_HOLD)) u_mtx (
    .clk       (CLK),
    .rst_n     (RST_N),
    .req0      (mtx_req0_s),
    .req1      (mtx_req1_s),
    .code0     (CODE0),
    .code1     (CODE1),
    .gnt       (MTX_GNT),
    .valid     (MTX_VALID),
    .code      (MTX_CODE),
    .valid_nxt (mtx_valid_nxt_s),
    .evt       (mtx_evt_s),
    .evt_stn   (mtx_evt_stn_s)
  );

  terminal_slot_arbiter #(.MAX_HOLD(MAX_HOLD)) u_led (
    .clk       (CLK),
    .rst_n     (RST_N),
    .req0      (led_req0_s),
    .req1      (led_req1_s),
    .code0     (CODE0),
    .code1     (CODE1),
    .gnt       (LED_GNT),
    .valid     (LED_VALID),
    .code      (LED_CODE),
    .valid_nxt (led_valid_nxt_s),
    .evt       (led_evt_s),
    .evt_stn   (led_evt_stn_s)
  );

  // 7-seg selector follows the newest grant event; the matrix wins a tie.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      seg_sel_r   <= 1'b0;
      seg_valid_r <= 1'b0;
    end else begin
      if (mtx_evt_s) begin
        seg_sel_r <= mtx_evt_stn_s;
      end else if (led_evt_s) begin
        seg_sel_r <= led_evt_stn_s;
      end else begin
        seg_sel_r <= seg_sel_r;
      end
      seg_valid_r <= mtx_valid_nxt_s | led_valid_nxt_s;
    end
  end

  assign SEG_SEL   = seg_sel_r;
  assign SEG_VALID = seg_valid_r;

endmodule

// File: tb/tb_terminal_arbiter.sv
// Directed bench for terminal_arbiter: two instances (MAX_HOLD=4 and 1) share
// stimulus and are compared every cycle against an ownership/tenure model.
module tb_terminal_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, req0, dst0, req1, dst1;
  logic [2:0] code0, code1;

  logic [1:0] mtx_gnt[2], led_gnt[2];
  logic       mtx_valid[2], led_valid[2], seg_sel[2], seg_valid[2];
  logic [2:0] mtx_code[2], led_code[2];

  int checks = 0;
  int errors = 0;

  int         hold[2] = '{4, 1};
  int         owner[2][2];   // [inst][terminal], -1 = nobody
  int         tenure[2][2];  // edges the current owner has held the terminal
  int         prefer[2][2];  // station favoured on the next simultaneous request
  logic [2:0] mcode[2][2];
  int         mseg[2];

  terminal_arbiter #(.MAX_HOLD(4)) dut (
    .CLK(clk), .RST_N(rst_n),
    .REQ0(req0), .DST0(dst0), .CODE0(code0),
    .REQ1(req1), .DST1(dst1), .CODE1(code1),
    .MTX_GNT(mtx_gnt[0]), .MTX_VALID(mtx_valid[0]), .MTX_CODE(mtx_code[0]),
    .LED_GNT(led_gnt[0]), .LED_VALID(led_valid[0]), .LED_CODE(led_code[0]),
    .SEG_SEL(seg_sel[0]), .SEG_VALID(seg_valid[0])
  );

  terminal_arbiter #(.MAX_HOLD(1)) dut_h1 (
    .CLK(clk), .RST_N(rst_n),
    .REQ0(req0), .DST0(dst0), .CODE0(code0),
    .REQ1(req1), .DST1(dst1), .CODE1(code1),
    .MTX_GNT(mtx_gnt[1]), .MTX_VALID(mtx_valid[1]), .MTX_CODE(mtx_code[1]),
    .LED_GNT(led_gnt[1]), .LED_VALID(led_valid[1]), .LED_CODE(led_code[1]),
    .SEG_SEL(seg_sel[1]), .SEG_VALID(seg_valid[1])
  );

  task automatic chk(input string nm, input int inst, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, inst, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mseg[i] = 0;
      for (int t = 0; t < 2; t++) begin
        owner[i][t] = -1; tenure[i][t] = 0; prefer[i][t] = 0; mcode[i][t] = 3'b000;
      end
    end
  endtask

  task automatic model_edge();
    logic [2:0] c[2];
    int         r[2];
    int         o, x, pick;
    bit         ev[2];
    int         evs[2];
    c[0] = code0; c[1] = code1;
    for (int i = 0; i < 2; i++) begin
      for (int t = 0; t < 2; t++) begin
        r[0] = (req0 && (int'(dst0) == t)) ? 1 : 0;
        r[1] = (req1 && (int'(dst1) == t)) ? 1 : 0;
        ev[t] = 1'b0; evs[t] = 0;
        o = owner[i][t];
        if (o < 0) begin
          if (r[0] + r[1] > 0) begin
            pick = (r[0] + r[1] == 2) ? prefer[i][t] : ((r[0] == 1) ? 0 : 1);
            owner[i][t] = pick; tenure[i][t] = 1; prefer[i][t] = 1 - pick;
            mcode[i][t] = c[pick]; ev[t] = 1'b1; evs[t] = pick;
          end else begin
            mcode[i][t] = 3'b000;
          end
        end else begin
          x = 1 - o;
          if (r[o] == 0) begin
            owner[i][t] = -1; tenure[i][t] = 0; prefer[i][t] = x; mcode[i][t] = 3'b000;
          end else if (r[x] == 1 && tenure[i][t] >= hold[i]) begin
            owner[i][t] = x; tenure[i][t] = 1; prefer[i][t] = o;
            mcode[i][t] = c[x]; ev[t] = 1'b1; evs[t] = x;
          end else begin
            tenure[i][t]++; mcode[i][t] = c[o];
          end
        end
      end
      if (ev[0]) mseg[i] = evs[0];
      else if (ev[1]) mseg[i] = evs[1];
    end
  endtask

  function automatic logic [1:0] gnt_of(input int o);
    return (o == 0) ? 2'b01 : ((o == 1) ? 2'b10 : 2'b00);
  endfunction

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk("mtx_gnt",   i, {6'd0, mtx_gnt[i]},   {6'd0, gnt_of(owner[i][0])});
      chk("mtx_valid", i, {7'd0, mtx_valid[i]}, {7'd0, owner[i][0] >= 0});
      chk("mtx_code",  i, {5'd0, mtx_code[i]},  {5'd0, mcode[i][0]});
      chk("led_gnt",   i, {6'd0, led_gnt[i]},   {6'd0, gnt_of(owner[i][1])});
      chk("led_valid", i, {7'd0, led_valid[i]}, {7'd0, owner[i][1] >= 0});
      chk("led_code",  i, {5'd0, led_code[i]},  {5'd0, mcode[i][1]});
      chk("seg_sel",   i, {7'd0, seg_sel[i]},   8'(mseg[i]));
      chk("seg_valid", i, {7'd0, seg_valid[i]}, {7'd0, (owner[i][0] >= 0) || (owner[i][1] >= 0)});
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    compare_all();
  endtask

  logic [1:0] exp_h4[10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01};

  initial begin
    rst_n = 1'b0; req0 = 1'b0; dst0 = 1'b0; req1 = 1'b0; dst1 = 1'b0;
    code0 = 3'b000; code1 = 3'b000;
    model_reset();
    step(); step();
    chk("rst_mtx_gnt", 0, {6'd0, mtx_gnt[0]}, 8'h00);
    chk("rst_seg_valid", 0, {7'd0, seg_valid[0]}, 8'h00);
    #2 rst_n = 1'b1;

    // Single request, code follows, release.
    req0 = 1'b1; dst0 = 1'b0; code0 = 3'b101;
    step();
    chk("t1_mtx_gnt", 0, {6'd0, mtx_gnt[0]}, 8'h01);
    chk("t1_mtx_code", 0, {5'd0, mtx_code[0]}, 8'h05);
    chk("t1_seg_sel", 0, {7'd0, seg_sel[0]}, 8'h00);
    chk("t1_seg_valid", 0, {7'd0, seg_valid[0]}, 8'h01);
    code0 = 3'b011;
    step();
    chk("t1_code_follow", 0, {5'd0, mtx_code[0]}, 8'h03);
    step(); step();
    req0 = 1'b0;
    step();
    chk("t1_rel_gnt", 0, {6'd0, mtx_gnt[0]}, 8'h00);
    chk("t1_rel_code", 0, {5'd0, mtx_code[0]}, 8'h00);
    step();

    // Round-robin after station 0 released: station 1 wins the tie.
    req0 = 1'b1; dst0 = 1'b0; req1 = 1'b1; dst1 = 1'b0; code0 = 3'b001; code1 = 3'b110;
    step();
    chk("t5_rr_gnt", 0, {6'd0, mtx_gnt[0]}, 8'h02);
    chk("t5_rr_gnt", 1, {6'd0, mtx_gnt[1]}, 8'h02);
    chk("t5_rr_code", 0, {5'd0, mtx_code[0]}, 8'h06);
    req0 = 1'b0; req1 = 1'b0;
    step(); step();

    // Split terminals: both grant on one edge, matrix wins the 7-seg.
    req0 = 1'b1; dst0 = 1'b0; req1 = 1'b1; dst1 = 1'b1; code0 = 3'b010; code1 = 3'b111;
    step();
    chk("t3_mtx_gnt", 0, {6'd0, mtx_gnt[0]}, 8'h01);
    chk("t3_led_gnt", 0, {6'd0, led_gnt[0]}, 8'h02);
    chk("t3_seg_sel", 0, {7'd0, seg_sel[0]}, 8'h00);

    // Redirect: station 1 moves from LEDs to the idle matrix.
    req0 = 1'b0;
    step();
    chk("t4_seg_hold", 0, {7'd0, seg_sel[0]}, 8'h00);
    dst1 = 1'b0;
    step();
    chk("t4_led_gnt", 0, {6'd0, led_gnt[0]}, 8'h00);
    chk("t4_mtx_gnt", 0, {6'd0, mtx_gnt[0]}, 8'h02);
    chk("t4_seg_sel", 0, {7'd0, seg_sel[0]}, 8'h01);

    // Reset mid-grant clears outputs immediately.
    #2 rst_n = 1'b0;
    model_reset();
    #1 compare_all();
    chk("t6_rst_gnt", 0, {6'd0, mtx_gnt[0]}, 8'h00);
    chk("t6_rst_seg", 0, {7'd0, seg_sel[0]}, 8'h00);
    req0 = 1'b1; dst0 = 1'b0; req1 = 1'b1; dst1 = 1'b0; code0 = 3'b100; code1 = 3'b011;
    step();
    #2 rst_n = 1'b1;

    // Contention after reset: station 0 first, bounded hold.
    for (int e = 0; e < 10; e++) begin
      step();
      chk("t2_h4_gnt", 0, {6'd0, mtx_gnt[0]}, {6'd0, exp_h4[e]});
      chk("t2_h1_gnt", 1, {6'd0, mtx_gnt[1]}, (e % 2 == 0) ? 8'h01 : 8'h02);
      if (e == 2) code0 = 3'b001;
    end

    // Saturated owner, late contender switches on the first shared edge.
    req1 = 1'b0;
    for (int k = 0; k < 6; k++) step();
    req1 = 1'b1;
    step();
    chk("sat_switch", 0, {6'd0, mtx_gnt[0]}, 8'h02);
    chk("sat_code", 0, {5'd0, mtx_code[0]}, 8'h03);

    // Owner redirect: matrix releases on the same edge the LEDs grant.
    req1 = 1'b0;
    step(); step();
    dst0 = 1'b1;
    step();
    chk("redir_led", 0, {6'd0, led_gnt[0]}, 8'h01);
    chk("redir_mtx", 0, {6'd0, mtx_gnt[0]}, 8'h00);
    req0 = 1'b0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/terminal_arbiter.md
Name: terminal_arbiter

Overview:
- Sequential arbiter that shares the two output terminals, the LED matrix and the LED bar, between the two input stations (station 0 and station 1).
- It sits between the per-station authentication/functionality encoders and the terminal decoders.
- It replaces the combinational terminal selector with per-terminal grant state, round-robin fairness and a bounded hold time.
- It also drives the 7-segment user-display selector.

Parameters:
MAX_HOLD, 8, maximum consecutive cycles a station keeps a contended terminal (>=1)
CNT_W, $clog2(MAX_HOLD) (min 1), hold counter width (derived, do not override)

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
REQ0  input  1  station 0 authenticated request (synchronous to CLK)
DST0  input  1  station 0 target terminal: 0 = matrix, 1 = LEDs
CODE0  input  3  station 0 encoded function
REQ1  input  1  station 1 request
DST1  input  1  station 1 target terminal
CODE1  input  3  station 1 encoded function
MTX_GNT  output  2  one-hot matrix owner ([0] = station 0)
MTX_VALID  output  1  matrix owned
MTX_CODE  output  3  function code to matrix decoder
LED_GNT  output  2  one-hot LED owner
LED_VALID  output  1  LEDs owned
LED_CODE  output  3  function code to LED decoder
SEG_SEL  output  1  station shown on 7-seg (0/1)
SEG_VALID  output  1  7-seg enabled

Behaviour:
- Reset (async, RST_N=0): both terminal FSMs go to IDLE, round-robin pointers = 0, counters = 0. All outputs are 0. Reset applies immediately, including in the middle of a grant. The first evaluation happens at the first rising edge after release.
- Per-terminal request: for terminal T, station i requests when REQi=1 and DSTi selects T. A station therefore requests at most one terminal per cycle.
- Per-terminal FSM states: IDLE, OWN0, OWN1. All outputs are registered.
- IDLE:
  - Only station i requesting -> OWNi.
  - Both requesting -> OWN[ptr].
  - Neither -> stay in IDLE.
  - Grant latency: request seen at edge k, GNT/VALID asserted after edge k.
- On entry to OWNi: counter := 0; CODE register := CODEi.
- OWNi, request i dropped: -> IDLE at the next edge. ptr := other station. CODE := 0.
- OWNi, request i held, other station not requesting: stay in OWNi. Counter increments and saturates at MAX_HOLD-1.
- OWNi, request i held, other station requesting:
  - Counter < MAX_HOLD-1: stay in OWNi, counter increments.
  - Counter == MAX_HOLD-1: go directly to OWN(other) with no IDLE cycle. Counter := 0; CODE := CODE(other); ptr := i.
- A saturated counter, with the other station arriving later, causes a switch on the first edge where both are requesting.
- MAX_HOLD=1: contended ownership alternates every cycle.
- While in OWNi, the CODE register follows CODEi every cycle, with 1-cycle latency.
- Destination change by the owner: the old terminal sees the request drop and releases (-> IDLE). The new terminal arbitrates in the same edge. The old terminal therefore goes IDLE at the same edge the new terminal grants.
- ptr on IDLE grant: set to the station not granted.
- Outputs:
  - GNT is the one-hot state; VALID = (state != IDLE).
  - CODE = 0 whenever IDLE.
  - A station never holds both terminals.
- SEG_SEL: updated to the station of the newest grant event (IDLE->OWN or OWN switch) on either terminal. If both terminals have grant events in the same edge, the matrix event wins. SEG_SEL holds its value otherwise, including after release.
- SEG_VALID = MTX_VALID | LED_VALID.

Decomposition:
- Shared package: state encoding constants (IDLE=2'b00, OWN0=2'b01, OWN1=2'b10), terminal selector constants (DST_MTX=0, DST_LED=1) and the code width (3).
- One sub-module, terminal_slot_arbiter: a single-terminal FSM with counter, pointer and CODE register. It is instantiated twice (matrix, LEDs).
- The top level contains the request steering and the SEG_SEL logic.

Test Plan:
1. Single request (MAX_HOLD=8): REQ0=1, DST0=0, CODE0=3'b101 at edge 1 -> after edge 1: MTX_GNT=01, MTX_CODE=101, SEG_SEL=0, SEG_VALID=1. Drop REQ0 at edge 5 -> after edge 5: MTX_GNT=00, MTX_CODE=000.
2. Contention (MAX_HOLD=4): both stations request the matrix from edge 1 -> OWN0 for edges 1-4, OWN1 for 5-8, OWN0 from 9. MTX_CODE follows the owner with no IDLE gap.
3. Split terminals: DST0=0, DST1=1, both REQ from edge 1 -> after edge 1: MTX_GNT=01, LED_GNT=10, SEG_SEL=0 (matrix wins the tie).
4. Redirect: station 1 owns the LEDs, then DST1 switches to 0 with the matrix idle -> at the same edge: LED_GNT=00, MTX_GNT=10, SEG_SEL=1.
5. Round-robin after release: station 0 owns and releases; both then request the same terminal simultaneously -> grant goes to station 1.
6. Reset mid-grant: RST_N=0 between edges while OWN1 -> outputs 0 immediately. After release with both requesting -> station 0 granted (ptr reset to 0).
